// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response bundle for the execute-stage ALU.
//   Request : in_valid, in_ready, ALU_control, a, b
//   Response: out_valid, out_ready, result, flag_n/z/c/v, err
//   master - the issuing side (decode/register-read stage or a testbench)
//   slave  - the ALU itself
interface alu_exec_unit_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALU_control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             err;

    modport master (
        output in_valid, ALU_control, a, b, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, err
    );

    modport slave (
        input  in_valid, ALU_control, a, b, out_ready,
        output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, err
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with a valid/ready handshake on both sides.
// Single-cycle ops (AND, OR, ADD, SUB, PASS) finish one clock after acceptance;
// MUL is a shift-and-add over 64 clocks. Result, NZCV flags and err stay
// registered and stable while the result waits in DONE.
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   bus   - slave side of alu_exec_unit_if (request, operands, response)
module alu_exec_unit #(
    parameter int unsigned WIDTH = 64
) (
    input logic           clk,
    input logic           reset,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] CODE_AND  = 4'b0000;
    localparam logic [3:0] CODE_OR   = 4'b0001;
    localparam logic [3:0] CODE_ADD  = 4'b0010;
    localparam logic [3:0] CODE_SUB  = 4'b0110;
    localparam logic [3:0] CODE_PASS = 4'b0111;
    localparam logic [3:0] CODE_MUL  = 4'b1000;

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] result_q;
    logic             flag_n_q, flag_z_q, flag_c_q, flag_v_q, err_q;

    logic             in_ready, out_valid, accept;

    // Single-cycle datapath
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] op_res;
    logic             op_c, op_v, op_err;

    // One multiply step: conditional add of the shifted multiplicand
    logic [WIDTH-1:0] acc_step;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    state_d = (bus.ALU_control == CODE_MUL) ? StMul : StDone;
                end
            end
            StMul: begin
                if (count_q == CNT_LAST) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs, decoded from state only
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    assign accept = bus.in_valid & in_ready;

    always_comb begin
        is_sub = (bus.ALU_control == CODE_SUB);
        // SUB is a + ~b + 1, so C=1 means no borrow
        b_eff  = is_sub ? ~bus.b : bus.b;
        sum    = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        op_res = '0;
        op_c   = 1'b0;
        op_v   = 1'b0;
        op_err = 1'b0;
        case (bus.ALU_control)
            CODE_AND:  op_res = bus.a & bus.b;
            CODE_OR:   op_res = bus.a | bus.b;
            CODE_PASS: op_res = bus.b;
            CODE_ADD, CODE_SUB: begin
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_v   = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            default:   op_err = 1'b1;
        endcase
    end

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (bus.ALU_control == CODE_MUL) begin
                            mcand_q  <= bus.a;
                            mplier_q <= bus.b;
                            acc_q    <= '0;
                            count_q  <= '0;
                        end else begin
                            // Unrecognised codes leave op_res at 0, so Z reads 1
                            result_q <= op_res;
                            flag_n_q <= op_res[WIDTH-1];
                            flag_z_q <= (op_res == '0);
                            flag_c_q <= op_c;
                            flag_v_q <= op_v;
                            err_q    <= op_err;
                        end
                    end
                end
                StMul: begin
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 1'b1;
                    if (count_q == CNT_LAST) begin
                        result_q <= acc_step;
                        flag_n_q <= acc_step[WIDTH-1];
                        flag_z_q <= (acc_step == '0);
                        flag_c_q <= 1'b0;
                        flag_v_q <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.flag_n    = flag_n_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_c    = flag_c_q;
    assign bus.flag_v    = flag_v_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with hand-computed results for alu_exec_unit.
module tb_alu_exec_unit;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_BAD  = 4'b1111;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(64)) bus ();

    alu_exec_unit #(.WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] nzcv();
        return {60'd0, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
    endfunction

    // Present one operation for one edge; operands are scrambled afterwards.
    task automatic issue(input logic [3:0] code, input logic [63:0] x, input logic [63:0] y);
        bus.in_valid    = 1'b1;
        bus.ALU_control = code;
        bus.a           = x;
        bus.b           = y;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.ALU_control = 4'b1010;
        bus.a           = ~x;
        bus.b           = ~y;
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".in_ready_after"}, 64'(bus.in_ready), 64'd1);
        check({tag, ".out_valid_after"}, 64'(bus.out_valid), 64'd0);
    endtask

    // Single-cycle op: result must already be valid one edge after acceptance.
    task automatic run_single(input string tag, input logic [3:0] code, input logic [63:0] x,
                              input logic [63:0] y, input logic [63:0] exp_res,
                              input logic [3:0] exp_fl, input logic exp_err);
        issue(code, x, y);
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, ".result"}, bus.result, exp_res);
        check({tag, ".nzcv"}, nzcv(), 64'(exp_fl));
        check({tag, ".err"}, 64'(bus.err), 64'(exp_err));
        consume(tag);
    endtask

    initial begin
        int cycles;
        int seen_valid;
        logic [63:0] held;

        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.ALU_control = 4'b0000;
        bus.a           = '0;
        bus.b           = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 64'(bus.in_ready), 64'd1);
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.result", bus.result, 64'd0);
        check("rst.nzcv", nzcv(), 64'd0);
        check("rst.err", 64'(bus.err), 64'd0);
        reset = 1'b0;

        run_single("add_ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                   64'h8000_0000_0000_0000, 4'b1001, 1'b0);
        run_single("sub_eq", OP_SUB, 64'd5, 64'd5, 64'd0, 4'b0110, 1'b0);
        run_single("sub_borrow", OP_SUB, 64'd0, 64'd1,
                   64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0);
        run_single("and", OP_AND, 64'hF0F0, 64'hFF00, 64'hF000, 4'b0000, 1'b0);
        run_single("or", OP_OR, 64'hF0F0, 64'hFF00, 64'hFFF0, 4'b0000, 1'b0);
        run_single("pass", OP_PASS, 64'hDEAD, 64'h1234, 64'h1234, 4'b0000, 1'b0);

        // MUL latency: out_valid must first appear 64 edges after acceptance
        issue(OP_MUL, 64'hFFFF_FFFF, 64'h1_0000_0001);
        check("mul.in_ready_busy", 64'(bus.in_ready), 64'd0);
        cycles = 0;
        while (!bus.out_valid && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("mul.latency", 64'(cycles), 64'd64);
        check("mul.result", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mul.nzcv", nzcv(), 64'b1000);
        check("mul.err", 64'(bus.err), 64'd0);

        // Backpressure with a competing request that must be ignored
        held            = bus.result;
        bus.in_valid    = 1'b1;
        bus.ALU_control = OP_ADD;
        bus.a           = 64'd1;
        bus.b           = 64'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp.result", bus.result, held);
            check("bp.in_ready", 64'(bus.in_ready), 64'd0);
            check("bp.out_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        consume("mul");

        // Reset in the middle of a MUL (count == 30)
        issue(OP_MUL, 64'd3, 64'd7);
        repeat (30) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rstmul.in_ready", 64'(bus.in_ready), 64'd1);
        check("rstmul.out_valid", 64'(bus.out_valid), 64'd0);
        check("rstmul.result", bus.result, 64'd0);
        check("rstmul.nzcv", nzcv(), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen_valid = 1;
        end
        check("rstmul.no_valid", 64'(seen_valid), 64'd0);
        run_single("add_after_rst", OP_ADD, 64'd2, 64'd3, 64'd5, 4'b0000, 1'b0);

        // Unrecognised code, then a valid op clears err
        run_single("bad_code", OP_BAD, 64'h1234, 64'h5678, 64'd0, 4'b0100, 1'b1);
        run_single("add_after_bad", OP_ADD, 64'd1, 64'd1, 64'd2, 4'b0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Sequential execute-stage ALU that consumes the 4-bit ALU_control code produced by ALU control decoding, together with two 64-bit operands, and returns a registered result with NZCV flags over a valid/ready handshake. Single-cycle operations (ADD, SUB, AND, ORR, PASS) complete one clock after acceptance. The iterative MUL operation completes 64 clocks after acceptance. The block sits between the register-read/decode boundary and the memory/writeback stage and is the consumer end of the ALU_control encoding.

## Interface
- WIDTH, 64, operand and result width; the counter and flag rules assume 64.
- CODE_AND = 4'b0000, CODE_OR = 4'b0001, CODE_ADD = 4'b0010, CODE_SUB = 4'b0110, CODE_PASS = 4'b0111. These are the same values as `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB` and `ALU_PASS` in definitions.vh.
- CODE_MUL = 4'b1000. This is new; it is added to definitions.vh as `ALU_MUL`.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept an operation.
- ALU_control  in  4  operation code.
- a  in  64  operand A (Rn).
- b  in  64  operand B (Rm, or the immediate).
- out_valid  out  1  result registers hold a completed result.
- out_ready  in  1  downstream takes the result.
- result  out  64  operation result.
- flag_n, flag_z, flag_c, flag_v  out  1 each  NZCV flags for result.
- err  out  1  the completed operation had an unrecognised code.

## Operation
- The FSM has three states: IDLE, MUL, DONE.
- in_ready = (state == IDLE). This output is combinational from state.
- out_valid = (state == DONE). This output is combinational from state.
- Acceptance happens on a clock edge where in_valid & in_ready. At that edge, ALU_control, a and b are captured.
- Accepted code not equal to CODE_MUL:
  - result, flags and err are computed and registered at the same edge.
  - IDLE→DONE.
- Accepted code equal to CODE_MUL:
  - Multiplicand register ← a, multiplier register ← b, accumulator ← 0, count ← 0.
  - IDLE→MUL.
- MUL state, on each edge:
  - If multiplier[0] is set, accumulator += multiplicand (mod 2^64).
  - Multiplicand <<= 1, multiplier >>= 1, count++.
  - On the edge where count == 63: result ← final accumulator, flags set, MUL→DONE.
- DONE state:
  - Outputs hold stable until out_valid & out_ready.
  - On that edge, DONE→IDLE.
  - No new operation is accepted in DONE.
- Arithmetic rules (all mod 2^64):
  - ADD: a + b.
  - SUB: a + ~b + 1.
  - AND: a & b.
  - OR: a | b.
  - PASS: result = b.
  - MUL: low 64 bits of a*b. Operands are treated as unsigned; the low half is identical for signed operands.
- Flag rules:
  - flag_n = result[63].
  - flag_z = (result == 0).
  - ADD/SUB: flag_c = carry out of bit 63 of the 65-bit sum (for SUB, C=1 means no borrow). flag_v = signed overflow, i.e. (a[63] == b'[63]) && (result[63] != a[63]), where b' = b for ADD and ~b for SUB.
  - AND/OR/PASS/MUL: flag_c = flag_v = 0.
- Unrecognised code:
  - The unit goes to DONE in one cycle.
  - result = 0, flag_z = 1, flag_n = flag_c = flag_v = 0, err = 1.
  - err = 0 for every valid code.
- in_valid is ignored outside IDLE. ALU_control, a and b may change freely after acceptance.

## Timing
- Reset (asynchronous, immediate):
  - State ← IDLE; the MUL count and internal registers are cleared.
  - result = 0, all flags = 0, err = 0, out_valid = 0, in_ready = 1.
- Single-cycle operations:
  - Accepted at edge T; out_valid is high after edge T+1's preceding state update, i.e. visible in the cycle following T.
  - If out_ready is already high, the handshake completes at T+1 and in_ready returns high after T+1.
  - Sustained throughput is one operation per 2 cycles.
- MUL:
  - Accepted at edge T; 64 MUL-state edges, T+1 through T+64.
  - out_valid is high after T+64. Latency is 64 cycles.
- Backpressure: with out_ready low, DONE holds indefinitely and result/flags do not change.
- Reset mid-MUL or in DONE: the operation is discarded and no out_valid pulse occurs. After reset deassertion the first edge may accept a new operation.
- Reset asserted on the same edge as an acceptance: reset wins and nothing is captured.

## Test plan
- Reset check, then ADD:
  - After reset: in_ready=1, out_valid=0, result=0, flags=0.
  - ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 → after 1 cycle: result=0x8000_0000_0000_0000, N=1, Z=0, C=0, V=1.
- SUB, equal operands: a=5, b=5 → result=0, Z=1, C=1, V=0.
- SUB, borrow: a=0, b=1 → result=0xFFFF_FFFF_FFFF_FFFF, N=1, C=0, V=0.
- AND, OR, PASS:
  - AND a=0xF0F0, b=0xFF00 → 0xF000.
  - OR a=0xF0F0, b=0xFF00 → 0xFFF0.
  - PASS a=0xDEAD, b=0x1234 → 0x1234.
  - For all three: C=V=0.
- MUL and backpressure:
  - MUL a=0xFFFF_FFFF, b=0x1_0000_0001 → out_valid exactly 64 cycles after acceptance, result=0xFFFF_FFFF_FFFF_FFFF, N=1, C=V=0.
  - Hold out_ready low for 10 cycles: result stays stable and in_ready stays 0.
- Reset at MUL count 30 → immediate IDLE, outputs 0, no out_valid. A subsequent ADD 2+3 returns 5.
- Unrecognised code 4'b1111 → after 1 cycle: err=1, result=0, Z=1. The next valid op returns err=0.
